// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder.
// The sub request exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ov;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, ci, sub, input busy, done, sum, co, ov);
  modport slave  (input start, a, b, ci, sub, output busy, done, sum, co, ov);
`else
  modport master (output start, a, b, ci, input busy, done, sum, co, ov);
  modport slave  (input start, a, b, ci, output busy, done, sum, co, ov);
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS-wide ripple slice per clock with a registered carry.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one slice per cycle, LSB slice first
// DONE  | one-cycle result strobe; start here relaunches immediately
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BITS  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave bus
);

  localparam int NC = WIDTH / BITS;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_ov;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_ci_eff;
  logic [IW-1:0]    w_base;
  logic [BITS-1:0]  w_a_sl;
  logic [BITS-1:0]  w_b_sl;
  logic [BITS:0]    w_slice;
  logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + ~ci, so ci acts as a borrow-in.
  assign w_b_eff  = bus.sub ? ~bus.b : bus.b;
  assign w_ci_eff = bus.ci ^ bus.sub;
`else
  assign w_b_eff  = bus.b;
  assign w_ci_eff = bus.ci;
`endif

  assign w_last = (r_cnt == CW'(NC - 1));

  always_comb begin
    w_base     = IW'(r_cnt) * IW'(BITS);
    w_a_sl     = r_a[w_base +: BITS];
    w_b_sl     = r_b[w_base +: BITS];
    w_slice    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{BITS{1'b0}}, r_carry};
    w_acc_next = r_acc;
    w_acc_next[w_base +: BITS] = w_slice[BITS-1:0];
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_next = S_RUN;
        w_load = 1'b1;
      end
      S_RUN: if (w_last) w_next = S_DONE;
      S_DONE: begin
        w_next = S_IDLE;
        if (bus.start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= w_b_eff;
      r_carry <= w_ci_eff;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_slice[BITS];
      r_cnt   <= r_cnt + CW'(1);
      // Only the final slice publishes, so sum never shows partial results.
      if (w_last) begin
        r_sum <= w_acc_next;
        r_co  <= w_slice[BITS];
        r_ov  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                 (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.co   = r_co;
  assign bus.ov   = r_ov;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that processes WIDTH-bit operands BITS slices at a time through a BITS-wide ripple full-adder chain and a registered carry. It is the sequential, width-generic successor of the single-bit full adder. It trades area for latency and exposes a start/busy/done handshake so a controller or testbench can launch back-to-back additions. An optional subtract mode is available.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 1 and a multiple of BITS.
- BITS, 1, bits processed per clock cycle; must be in 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ci  input  1  carry-in; sampled with start.
- sub  input  1  subtract request; sampled with start. Present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; sum, co and ov are valid.
- sum  output  WIDTH  result; holds its value until the next done.
- co  output  1  carry-out of bit WIDTH-1.
- ov  output  1  two's-complement signed overflow of the result.

## Operation
- Clocking and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Slice count: NC = WIDTH/BITS.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1:
  - latch a, b and the carry register (ci).
  - clear the slice counter.
- RUN, each cycle:
  - add slice[cnt] of A, slice[cnt] of B and the carry register, LSB slice first.
  - write the BITS result bits into sum slice[cnt].
  - store the slice carry-out in the carry register.
  - increment cnt.
- RUN → DONE after slice NC-1 is processed:
  - co = final carry.
  - ov = (A[WIDTH-1] == B'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]), where B' is the effective B operand.
- DONE → RUN when start=1; operands are latched exactly as from IDLE.
- DONE → IDLE otherwise.
- start while busy=1 is ignored; operand inputs may change freely during RUN.
- sum is built in a result register. The visible sum output updates only on the transition into DONE, so it never exposes partial results.
- Arithmetic: {co, sum} = A + B' + ci, modulo 2^(WIDTH+1). No saturation.

## Timing
- Reset values: busy=0, done=0, sum=0, co=0, ov=0, state IDLE, cnt=0, carry register 0.
- Start is accepted at clock edge k.
- busy=1 after edges k through k+NC-1; busy=0 after edge k+NC.
- done=1 for exactly one cycle, after edge k+NC.
- Latency from start edge to done is NC cycles.
- Back-to-back: start held high during the DONE cycle launches the next operation. Throughput is one result per NC+1 cycles.
- rst=1 at any point, including mid-RUN or during DONE:
  - aborts the operation and returns all outputs to reset values on that edge.
  - no done pulse is produced for the aborted operation.
  - rst has priority over start.
- WIDTH=BITS: single RUN cycle, NC=1, latency 1.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists.
  - with sub=1 at start, B' = ~b and the initial carry register = ~ci, so the result is A − B − (borrow-in ci).
  - co=1 means no borrow.
  - ov uses B'.
- SERIAL_ADDER_SUB_EN undefined:
  - no sub port and no inverter logic.
  - B' = b; addition only.

## Test plan
- WIDTH=8, BITS=1: a=0x7F, b=0x01, ci=0, start pulsed → done exactly 8 cycles later; sum=0x80, co=0, ov=1; busy high for 8 cycles.
- WIDTH=8, BITS=4: a=0xFF, b=0x01, ci=1 → done after 2 cycles; sum=0x01, co=1, ov=0; sum holds 0x01 afterward.
- Back-to-back, WIDTH=8, BITS=2: start held high; ops 0x10+0x20, then 0xF0+0x20 → done pulses 5 cycles apart; sums 0x30/co=0, then 0x10/co=1. Start pulses during RUN are ignored.
- Reset mid-RUN: rst=1 for one cycle at RUN cycle 3 of an 8-cycle op → busy=0, sum=0, co=0, no done pulse. A following op 0x05+0x03 gives sum=0x08.
- SERIAL_ADDER_SUB_EN, WIDTH=8, BITS=1: sub=1, a=0x05, b=0x07, ci=0 → sum=0xFE, co=0. With a=0x80, b=0x01 → sum=0x7F, ov=1, co=1.
- Exhaustive, WIDTH=4, BITS=1 and BITS=4: all a, b, ci combinations → {co, sum} matches the reference sum a+b+ci, and ov matches the signed rule.
